// File: rtl/eros_obi_pkg.sv
// eros_obi_pkg: shared types and constants for the AXI4-Lite to OBI bridge.
//   - AXI4-Lite request/response channel structs (32-bit address and data)
//   - OBI request/response structs
//   - bridge FSM state encoding and AXI-Lite response codes
//   - default address window used by the optional range check
package eros_obi_pkg;

  localparam int unsigned AXIL_ADDR_W = 32;
  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

  // Default window of the system address map (exclusive upper bound).
  localparam logic [AXIL_ADDR_W-1:0] GLOBAL_BASE_ADDRESS = 32'h0000_0000;
  localparam logic [AXIL_ADDR_W-1:0] GLOBAL_END_ADDRESS  = 32'h8000_0000;

  localparam logic [1:0]             AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0]             AXIL_RESP_SLVERR = 2'b10;
  localparam logic [AXIL_DATA_W-1:0] AXIL_ERR_RDATA   = 32'hBADCAB1E;

  typedef enum logic [2:0] {
    IDLE,
    W_REQ,
    W_WAIT,
    B_SEND,
    R_REQ,
    R_WAIT,
    R_SEND
  } axil_obi_state_e;

  typedef struct packed {
    logic [AXIL_ADDR_W-1:0] addr;
  } axil_ax_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } axil_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axil_b_t;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [1:0]             resp;
  } axil_r_t;

  typedef struct packed {
    axil_ax_t aw;
    logic     aw_valid;
    axil_w_t  w;
    logic     w_valid;
    logic     b_ready;
    axil_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axil_lite_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    axil_b_t b;
    logic    b_valid;
    logic    ar_ready;
    axil_r_t r;
    logic    r_valid;
  } axil_lite_rsp_t;

  typedef struct packed {
    logic                   req;
    logic                   we;
    logic [AXIL_STRB_W-1:0] be;
    logic [AXIL_ADDR_W-1:0] addr;
    logic [AXIL_DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic                   gnt;
    logic                   rvalid;
    logic [AXIL_DATA_W-1:0] rdata;
  } obi_resp_t;

  // True when addr lies outside [base, end).
  function automatic logic outside_window(input logic [AXIL_ADDR_W-1:0] addr,
                                          input logic [AXIL_ADDR_W-1:0] base,
                                          input logic [AXIL_ADDR_W-1:0] lim);
    return (addr < base) || (addr >= lim);
  endfunction

endpackage

// File: rtl/eros_axil_to_obi.sv
// eros_axil_to_obi: AXI4-Lite slave to OBI master bridge.
// One AXI-Lite transaction is in flight at a time and becomes exactly one OBI
// request. Simultaneous write and read candidates are arbitrated round-robin.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous reset, active low
//   axil_req_i  AXI-Lite request (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready)
//   axil_rsp_o  AXI-Lite response (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid)
//   obi_req_o   OBI request (req, we, be, addr, wdata)
//   obi_rsp_i   OBI response (gnt, rvalid, rdata)
//   busy_o      high whenever the bridge is not idle
//
// Configuration
//   EROS_AXIL_OBI_RANGE_CHECK_EN  when defined, accesses outside [BaseAddr, EndAddr) are
//                                 answered with SLVERR (reads return AXIL_ERR_RDATA) without
//                                 touching OBI. When undefined every access is forwarded.
module eros_axil_to_obi
  import eros_obi_pkg::*;
#(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter logic [31:0] BaseAddr   = GLOBAL_BASE_ADDRESS,
  parameter logic [31:0] EndAddr    = GLOBAL_END_ADDRESS,
  parameter type         axil_req_t = axil_lite_req_t,
  parameter type         axil_rsp_t = axil_lite_rsp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axil_req_t axil_req_i,
  output axil_rsp_t axil_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_rsp_i,
  output logic      busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam logic [AddrWidth-1:0] WordMask = ~(AddrWidth'(3));

  // Elaboration-time parameter sanity checks.
  if (DataWidth != 32) begin : g_bad_data_width
    $error("eros_axil_to_obi: DataWidth must be 32");
  end
  if (AddrWidth != 32) begin : g_bad_addr_width
    $error("eros_axil_to_obi: AddrWidth must be 32");
  end
  if (EndAddr <= BaseAddr) begin : g_bad_window
    $error("eros_axil_to_obi: EndAddr must be above BaseAddr");
  end

  axil_obi_state_e        state_q, state_d;
  logic                   prio_rd_q, prio_rd_d;  // 0: write wins a tie, 1: read wins
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [StrbWidth-1:0]   be_q, be_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [1:0]             resp_q, resp_d;

  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic aw_err, ar_err;

  assign wr_elig  = axil_req_i.aw_valid & axil_req_i.w_valid;
  assign rd_elig  = axil_req_i.ar_valid;
  assign grant_wr = wr_elig & (~rd_elig | ~prio_rd_q);
  assign grant_rd = rd_elig & (~wr_elig |  prio_rd_q);

`ifdef EROS_AXIL_OBI_RANGE_CHECK_EN
  assign aw_err = outside_window(axil_req_i.aw.addr, BaseAddr, EndAddr);
  assign ar_err = outside_window(axil_req_i.ar.addr, BaseAddr, EndAddr);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign busy_o = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    prio_rd_d  = prio_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    axil_rsp_o = '0;
    obi_req_o  = '0;

    unique case (state_q)
      IDLE: begin
        // Ready is combinational so accept happens in the same cycle valid is seen.
        if (grant_wr) begin
          axil_rsp_o.aw_ready = 1'b1;
          axil_rsp_o.w_ready  = 1'b1;
          addr_d              = axil_req_i.aw.addr;
          wdata_d             = axil_req_i.w.data;
          be_d                = axil_req_i.w.strb;
          prio_rd_d           = ~prio_rd_q;
          if (aw_err) begin
            resp_d  = AXIL_RESP_SLVERR;
            state_d = B_SEND;
          end else begin
            resp_d  = AXIL_RESP_OKAY;
            state_d = W_REQ;
          end
        end else if (grant_rd) begin
          axil_rsp_o.ar_ready = 1'b1;
          addr_d              = axil_req_i.ar.addr;
          prio_rd_d           = ~prio_rd_q;
          if (ar_err) begin
            resp_d  = AXIL_RESP_SLVERR;
            rdata_d = AXIL_ERR_RDATA;
            state_d = R_SEND;
          end else begin
            resp_d  = AXIL_RESP_OKAY;
            state_d = R_REQ;
          end
        end
      end

      W_REQ: begin
        obi_req_o.req   = 1'b1;
        obi_req_o.we    = 1'b1;
        obi_req_o.be    = be_q;
        obi_req_o.addr  = addr_q & WordMask;
        obi_req_o.wdata = wdata_q;
        if (obi_rsp_i.gnt) state_d = W_WAIT;
      end

      // Only entered after gnt, so an rvalid coinciding with gnt is never seen here.
      W_WAIT: begin
        if (obi_rsp_i.rvalid) state_d = B_SEND;
      end

      B_SEND: begin
        axil_rsp_o.b_valid = 1'b1;
        axil_rsp_o.b.resp  = resp_q;
        if (axil_req_i.b_ready) state_d = IDLE;
      end

      R_REQ: begin
        obi_req_o.req  = 1'b1;
        obi_req_o.we   = 1'b0;
        obi_req_o.be   = '1;
        obi_req_o.addr = addr_q & WordMask;
        if (obi_rsp_i.gnt) state_d = R_WAIT;
      end

      R_WAIT: begin
        if (obi_rsp_i.rvalid) begin
          rdata_d = obi_rsp_i.rdata;
          state_d = R_SEND;
        end
      end

      R_SEND: begin
        axil_rsp_o.r_valid = 1'b1;
        axil_rsp_o.r.data  = rdata_q;
        axil_rsp_o.r.resp  = resp_q;
        if (axil_req_i.r_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      prio_rd_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      resp_q    <= AXIL_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      prio_rd_q <= prio_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

endmodule

// File: tb/tb_eros_axil_to_obi.sv
`timescale 1ns/1ps
module tb_eros_axil_to_obi;
  import eros_obi_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  axil_lite_req_t axil_req;
  axil_lite_rsp_t axil_rsp;
  obi_req_t       obi_req;
  obi_resp_t      obi_rsp;
  logic           busy;

  // AXI-side stimulus, one driver process per variable group
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [3:0]  w_strb;
  logic        aw_valid, w_valid, ar_valid, b_ready, r_ready;

  always #5 clk = ~clk;

  always_comb begin
    axil_req          = '0;
    axil_req.aw.addr  = aw_addr;
    axil_req.aw_valid = aw_valid;
    axil_req.w.data   = w_data;
    axil_req.w.strb   = w_strb;
    axil_req.w_valid  = w_valid;
    axil_req.b_ready  = b_ready;
    axil_req.ar.addr  = ar_addr;
    axil_req.ar_valid = ar_valid;
    axil_req.r_ready  = r_ready;
  end

  eros_axil_to_obi dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .axil_req_i (axil_req),
    .axil_rsp_o (axil_rsp),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (obi_rsp),
    .busy_o     (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model: a plain word memory ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] v = old;
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i+:8] = d[8*i+:8];
    return v;
  endfunction

  logic [31:0] ref_mem [logic [31:0]];  // what AXI software should observe
  logic [31:0] dev_mem [logic [31:0]];  // contents of the OBI slave

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic bit rejected(input logic [31:0] a);
`ifdef EROS_AXIL_OBI_RANGE_CHECK_EN
    return (a < GLOBAL_BASE_ADDRESS) || (a >= GLOBAL_END_ADDRESS);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_rsp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_obi_t;

  exp_rsp_t exp_b[$], exp_r[$];
  exp_obi_t exp_obi[$];
  bit       acc_order[$];  // 1 = write accepted, 0 = read accepted

  // directed-test knobs
  int slv_stall = -1;  // -1: random gnt delay
  int slv_rdly  = -1;  // -1: random rvalid delay
  bit chk_lat   = 1'b0;
  bit rand_ready = 1'b0;
  bit hold_b    = 1'b0;
  int obi_grants = 0;
  int last_req_cycles = 0;

  // ---------------- OBI slave ----------------
  initial begin : obi_slave
    int          stall, rwait, reqcyc;
    bit          pend;
    obi_req_t    first;
    logic [31:0] rd, a;
    exp_obi_t    e;
    stall = -1; rwait = 0; reqcyc = 0; pend = 0; rd = '0; first = '0;
    obi_rsp = '0;
    forever begin
      @(posedge clk); #1;
      obi_rsp.gnt    = 1'b0;
      obi_rsp.rvalid = 1'b0;
      obi_rsp.rdata  = $urandom;  // junk unless rvalid
      if (!rst_n) begin
        pend = 0; stall = -1;
        continue;
      end
      if (pend) begin
        if (rwait == 0) begin
          obi_rsp.rvalid = 1'b1;
          obi_rsp.rdata  = rd;
          pend = 0;
        end else rwait--;
      end else if (obi_req.req) begin
        if (stall < 0) begin
          stall  = (slv_stall >= 0) ? slv_stall : $urandom_range(0, 3);
          first  = obi_req;
          reqcyc = 0;
        end else begin
          chk_eq("obi_req_stable", {obi_req.we, obi_req.be, obi_req.addr, obi_req.wdata},
                 {first.we, first.be, first.addr, first.wdata});
        end
        reqcyc++;
        if (stall == 0) begin
          obi_rsp.gnt = 1'b1;
          stall = -1;
          obi_grants++;
          last_req_cycles = reqcyc;
          chk_eq("obi_req_expected", exp_obi.size() > 0, 1);
          if (exp_obi.size() > 0) begin
            e = exp_obi.pop_front();
            chk_eq("obi_we", obi_req.we, e.we);
            chk_eq("obi_be", obi_req.be, e.be);
            chk_eq("obi_addr", obi_req.addr, e.addr);
            if (e.we) chk_eq("obi_wdata", obi_req.wdata, e.wdata);
          end
          a = obi_req.addr;
          if (obi_req.we) begin
            dev_mem[a] = merge(dev_rd(a), obi_req.wdata, obi_req.be);
            rd = $urandom;
          end else rd = dev_rd(a);
          pend  = 1;
          rwait = (slv_rdly >= 0) ? slv_rdly : $urandom_range(0, 2);
        end else stall--;
      end
    end
  end

  // ---------------- AXI response ready driver ----------------
  initial begin : ready_drv
    b_ready = 1'b0;
    r_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      b_ready = !hold_b && (!rand_ready || $urandom_range(0, 3) != 0);
      r_ready = !rand_ready || $urandom_range(0, 3) != 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit          b_seen, r_seen, b_hold, r_hold;
  logic [1:0]  b_hold_resp;
  logic [33:0] r_hold_val;

  initial begin : monitor
    exp_rsp_t    e;
    logic [31:0] a;
    bit          err;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        b_seen = 0; r_seen = 0; b_hold = 0; r_hold = 0;
        continue;
      end
      // accepts: expectations come from the stimulus, never from DUT outputs
      if (aw_valid && w_valid && axil_rsp.aw_ready) begin
        chk_eq("w_ready_with_aw", axil_rsp.w_ready, 1);
        chk_eq("single_accept", axil_rsp.ar_ready, 0);
        acc_order.push_back(1'b1);
        a   = aw_addr;
        err = rejected(a);
        if (!err) begin
          exp_obi.push_back('{1'b1, w_strb, a & ~32'h3, w_data});
          ref_mem[a & ~32'h3] = merge(ref_rd(a & ~32'h3), w_data, w_strb);
        end
        exp_b.push_back('{err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY, 32'h0, cyc,
                          chk_lat ? (err ? 1 : 3) : -1});
      end
      if (ar_valid && axil_rsp.ar_ready) begin
        chk_eq("single_accept_r", axil_rsp.aw_ready, 0);
        acc_order.push_back(1'b0);
        a   = ar_addr;
        err = rejected(a);
        if (!err) exp_obi.push_back('{1'b0, 4'hF, a & ~32'h3, 32'h0});
        exp_r.push_back('{err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY,
                          err ? 32'hBADCAB1E : ref_rd(a & ~32'h3), cyc,
                          chk_lat ? (err ? 1 : 3) : -1});
      end
      if (axil_rsp.b_valid && axil_rsp.r_valid) chk_eq("b_r_exclusive", 1, 0);
      if (axil_rsp.b_valid || axil_rsp.r_valid || obi_req.req) chk_eq("busy", busy, 1);
      if (b_hold) chk_eq("b_held", {axil_rsp.b_valid, axil_rsp.b.resp}, {1'b1, b_hold_resp});
      if (r_hold) chk_eq("r_held", {axil_rsp.r_valid, axil_rsp.r.data, axil_rsp.r.resp},
                         {1'b1, r_hold_val});
      b_hold      = axil_rsp.b_valid && !b_ready;
      b_hold_resp = axil_rsp.b.resp;
      r_hold      = axil_rsp.r_valid && !r_ready;
      r_hold_val  = {axil_rsp.r.data, axil_rsp.r.resp};
      // write responses
      if (axil_rsp.b_valid && !b_seen) begin
        b_seen = 1;
        chk_eq("b_expected", exp_b.size() > 0, 1);
        if (exp_b.size() > 0 && exp_b[0].lat >= 0)
          chk_eq("b_latency", cyc - exp_b[0].acc, exp_b[0].lat);
      end
      if (axil_rsp.b_valid && b_ready) begin
        b_seen = 0;
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          chk_eq("b_resp", axil_rsp.b.resp, e.resp);
        end
      end
      // read responses
      if (axil_rsp.r_valid && !r_seen) begin
        r_seen = 1;
        chk_eq("r_expected", exp_r.size() > 0, 1);
        if (exp_r.size() > 0 && exp_r[0].lat >= 0)
          chk_eq("r_latency", cyc - exp_r[0].acc, exp_r[0].lat);
      end
      if (axil_rsp.r_valid && r_ready) begin
        r_seen = 0;
        if (exp_r.size() > 0) begin
          e = exp_r.pop_front();
          chk_eq("r_resp", axil_rsp.r.resp, e.resp);
          chk_eq("r_data", axil_rsp.r.data, e.data);
        end
      end
    end
  end

  // ---------------- AXI request drivers ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    aw_addr = a; w_data = d; w_strb = s;
    aw_valid = 1'b1; w_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!axil_rsp.aw_ready && n < 200);
    chk_eq("aw_accept", axil_rsp.aw_ready, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0; w_valid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a);
    int n = 0;
    ar_addr = a;
    ar_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!axil_rsp.ar_ready && n < 200);
    chk_eq("ar_accept", axil_rsp.ar_ready, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy || exp_b.size() != 0 || exp_r.size() != 0) && n < lim) begin
      @(negedge clk); n++;
    end
    chk_eq("drain", {busy, exp_b.size() != 0, exp_r.size() != 0}, 3'b000);
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ref_mem[a] = d;
    dev_mem[a] = d;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int g0, n;
    aw_addr = '0; w_data = '0; w_strb = '0; ar_addr = '0;
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_axil_rsp", axil_rsp, '0);
    chk_eq("rst_obi_req", obi_req, '0);
    chk_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Arbitration straight after reset: write first, then read, twice.
    for (int k = 0; k < 2; k++) begin
      fork
        axi_write(32'h0000_1100 + 32'(k * 8), 32'hA000_0000 + 32'(k), 4'hF);
        axi_read(32'h0000_1104 + 32'(k * 8));
      join
      wait_idle(200);
    end
    chk_eq("arb_order", {acc_order[0], acc_order[1], acc_order[2], acc_order[3]}, 4'b1010);

    // Write with immediate gnt and rvalid: B at accept + 3.
    slv_stall = 0; slv_rdly = 0; chk_lat = 1'b1; rand_ready = 1'b0;
    axi_write(32'h0000_1010, 32'hDEADBEEF, 4'hF);
    wait_idle(50);

    // Read with gnt stalled 4 cycles: request held 5 cycles.
    preload(32'h0000_1014, 32'h12345678);
    slv_stall = 4; chk_lat = 1'b0;
    axi_read(32'h0000_1014);
    wait_idle(50);
    chk_eq("req_cycles_stalled", last_req_cycles, 5);

    // B back-pressure: response held, no new accept, no OBI activity.
    slv_stall = 0;
    hold_b = 1'b1;
    axi_write(32'h0000_1020, 32'h0BAD_F00D, 4'b0101);
    n = 0;
    do begin @(negedge clk); n++; end while (!axil_rsp.b_valid && n < 20);
    chk_eq("b_valid_arrives", axil_rsp.b_valid, 1);
    @(posedge clk); #1;
    g0 = obi_grants;
    fork
      axi_read(32'h0000_1020);
    join_none
    repeat (6) begin
      @(negedge clk);
      chk_eq("bp_b_valid", axil_rsp.b_valid, 1);
      chk_eq("bp_ar_ready", axil_rsp.ar_ready, 0);
      chk_eq("bp_obi_req", obi_req.req, 0);
    end
    chk_eq("bp_no_grant", obi_grants - g0, 0);
    @(posedge clk); #1;
    hold_b = 1'b0;
    wait fork;
    wait_idle(50);

    // Access at the window end: rejected with SLVERR only when the range check is built in.
    slv_stall = 0; slv_rdly = 0; chk_lat = 1'b1;
    g0 = obi_grants;
    axi_read(GLOBAL_END_ADDRESS);
    wait_idle(50);
`ifdef EROS_AXIL_OBI_RANGE_CHECK_EN
    chk_eq("end_addr_obi_grants", obi_grants - g0, 0);
`else
    chk_eq("end_addr_obi_grants", obi_grants - g0, 1);
`endif
    chk_lat = 1'b0;

    // Reset while waiting for rvalid: outputs drop at once, next read is normal.
    slv_stall = 0; slv_rdly = 8;
    g0 = obi_grants;
    axi_write(32'h0000_1030, 32'hCAFE_0123, 4'hF);
    n = 0;
    while (obi_grants == g0 && n < 20) begin @(negedge clk); n++; end
    chk_eq("w_wait_reached", obi_grants - g0, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_axil_rsp", axil_rsp, '0);
    chk_eq("midrst_obi_req", obi_req, '0);
    chk_eq("midrst_busy", busy, 0);
    exp_b.delete(); exp_r.delete(); exp_obi.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    slv_rdly = -1; slv_stall = -1;
    @(posedge clk); #1;
    axi_read(32'h0000_1030);
    wait_idle(100);

    // Concurrent random traffic.
    rand_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          axi_write(32'h0000_1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          axi_read(32'h0000_1000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3)));
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
    join
    wait_idle(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
